// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared widths, channel ids and response-pipeline types for the
//               unified word-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  // Conventional channel assignments on the core side
  localparam int CH_IMEM = 0;
  localparam int CH_DMEM = 1;

  // Channel index carried through the response pipeline. The width is fixed
  // at package level (up to 16 requesters) because a package cannot follow
  // the NUM_CH parameter of each arbiter instance.
  localparam int CH_W = 4;
  typedef logic [CH_W-1:0] ch_idx_t;

  // One slot of the response shift pipeline
  typedef struct packed {
    logic    valid;
    ch_idx_t ch;
    logic    is_store;
  } resp_stage_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Per-cycle grant generator for the memory arbiter. Produces a
//               one-hot (or zero) grant from the request vector. Fixed
//               priority by default; rotating priority with a pointer that
//               advances past each winner when ARB_ROUND_ROBIN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt
);

`ifdef ARB_ROUND_ROBIN_EN
  ch_idx_t ptr_q;
  ch_idx_t ptr_d;
  logic    w_found;

  // Rotating pick: requesters at or above the pointer beat those below it;
  // a grant is always an accept, so the pointer moves past every winner.
  always_comb begin
    gnt     = '0;
    ptr_d   = ptr_q;
    w_found = 1'b0;
    if (!clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_found && req[i] && (i >= int'(ptr_q))) begin
          gnt[i]  = 1'b1;
          w_found = 1'b1;
          ptr_d   = (i == NUM_CH - 1) ? '0 : ch_idx_t'(i + 1);
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_found && req[i] && (i < int'(ptr_q))) begin
          gnt[i]  = 1'b1;
          w_found = 1'b1;
          ptr_d   = (i == NUM_CH - 1) ? '0 : ch_idx_t'(i + 1);
        end
      end
    end
  end

  // Priority pointer register, back to channel 0 on reset
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic w_found;
  logic unused_clk;

  // Fixed priority keeps no state, so the clock is not needed here
  assign unused_clk = clk;

  // Lowest-index requester wins; nothing is granted while in reset
  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    if (!clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_found && req[i]) begin
          gnt[i]  = 1'b1;
          w_found = 1'b1;
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Unified word memory shared by NUM_CH requesters with per-
//               channel req/gnt/rvalid handshake, one access per cycle and a
//               LAT-cycle in-order response pipeline.
//               Optional macro ARB_ROUND_ROBIN_EN selects round-robin
//               arbitration (default: fixed priority, channel 0 highest).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 1024,
  parameter int AW     = 32,
  parameter int LAT    = 1
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic [NUM_CH-1:0]              req,
  input  logic [NUM_CH-1:0]              we,
  input  logic [NUM_CH-1:0][BE_W-1:0]    byteEnable,
  input  logic [NUM_CH-1:0][AW-1:0]      addr,
  input  logic [NUM_CH-1:0][WORD_W-1:0]  wdata,
  output logic [NUM_CH-1:0]              gnt,
  output logic [NUM_CH-1:0]              rvalid,
  output logic [NUM_CH-1:0][WORD_W-1:0]  rdata
);

  localparam int C_IDX_W = $clog2(DEPTH);

  logic                w_acc;
  ch_idx_t             w_sel;
  logic                w_we;
  logic [BE_W-1:0]     w_be;
  logic [AW-1:0]       w_addr;
  logic [WORD_W-1:0]   w_wdata;
  logic [C_IDX_W-1:0]  w_idx;
  logic                unused_addr;
  logic [WORD_W-1:0]   w_resp_data;

  logic [WORD_W-1:0]   mem_q   [DEPTH];
  resp_stage_t         stage_q [LAT];
  resp_stage_t         stage_d [LAT];
  logic [WORD_W-1:0]   data_q  [LAT];
  logic [WORD_W-1:0]   data_d  [LAT];
  logic [WORD_W-1:0]   hold_q  [NUM_CH];
  logic [WORD_W-1:0]   hold_d  [NUM_CH];

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk (clk),
    .clr (clr),
    .req (req),
    .gnt (gnt)
  );

  // Route the granted channel's request fields to the single memory port
  always_comb begin
    w_sel   = '0;
    w_we    = 1'b0;
    w_be    = '0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        w_sel   = ch_idx_t'(i);
        w_we    = we[i];
        w_be    = byteEnable[i];
        w_addr  = addr[i];
        w_wdata = wdata[i];
      end
    end
  end

  assign w_acc = |gnt;

  // Word index; byte offset and bits above the array size are ignored so
  // addresses alias modulo DEPTH*4
  assign w_idx       = w_addr[C_IDX_W+1:2];
  assign unused_addr = ^w_addr;

  // Byte-lane write at the accept edge; contents survive reset
  always_ff @(posedge clk) begin
    if (w_acc && w_we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (w_be[k]) begin
          mem_q[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
        end
      end
    end
  end

  // Next pipeline contents: new access enters stage 0, older ones shift on.
  // The word is captured at acceptance so later stores cannot disturb it.
  always_comb begin
    stage_d[0].valid    = w_acc;
    stage_d[0].ch       = w_sel;
    stage_d[0].is_store = w_we;
    data_d[0]           = mem_q[w_idx];
    for (int k = 1; k < LAT; k++) begin
      stage_d[k] = stage_q[k-1];
      data_d[k]  = data_q[k-1];
    end
  end

  // Decode the last stage to per-channel responses; rdata holds between pulses
  always_comb begin
    rvalid      = '0;
    rdata       = '0;
    w_resp_data = stage_q[LAT-1].is_store ? '0 : data_q[LAT-1];
    for (int i = 0; i < NUM_CH; i++) begin
      rvalid[i] = stage_q[LAT-1].valid && (stage_q[LAT-1].ch == ch_idx_t'(i));
      hold_d[i] = rvalid[i] ? w_resp_data : hold_q[i];
      rdata[i]  = hold_d[i];
    end
  end

  // Response pipeline and output hold registers; reset drops in-flight work
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int k = 0; k < LAT; k++) begin
        stage_q[k] <= '0;
        data_q[k]  <= '0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter (NUM_CH=2, DEPTH=16,
//               LAT=3). A transaction-level model predicts grants, response
//               timing and data every cycle; directed sequences add literal
//               expectations. Honours ARB_ROUND_ROBIN_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 16;
  localparam int AW     = 32;
  localparam int LAT    = 3;

  logic                      clk = 1'b0;
  logic                      clr = 1'b1;
  logic [NUM_CH-1:0]         req = '0;
  logic [NUM_CH-1:0]         we = '0;
  logic [NUM_CH-1:0][3:0]    byteEnable = '0;
  logic [NUM_CH-1:0][AW-1:0] addr = '0;
  logic [NUM_CH-1:0][31:0]   wdata = '0;
  logic [NUM_CH-1:0]         gnt;
  logic [NUM_CH-1:0]         rvalid;
  logic [NUM_CH-1:0][31:0]   rdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .AW     (AW),
    .LAT    (LAT)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .req        (req),
    .we         (we),
    .byteEnable (byteEnable),
    .addr       (addr),
    .wdata      (wdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ncyc   = 0;

  // ---------------- model state ----------------
  typedef struct { int due; int ch; logic [31:0] data; } exp_t;
  typedef struct { int ch; logic [31:0] data; int t; } obs_t;

  logic [31:0] mm [DEPTH];
  logic [31:0] hold [NUM_CH];
  int          rr_next = 0;
  exp_t        rq[$];
  obs_t        rlog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Channel that should win given the requests and the next-priority channel
  function automatic int model_pick(input logic [NUM_CH-1:0] r, input int start);
    int c;
    for (int k = 0; k < NUM_CH; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      c = (start + k) % NUM_CH;
`else
      c = k + 0 * start;
`endif
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Per-cycle comparison against the model; also commits predicted accepts
  initial begin
    int win;
    int idx;
    logic [NUM_CH-1:0] eg;
    logic [NUM_CH-1:0] ev;
    logic [31:0] d;
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      eg  = '0;
      ev  = '0;
      win = -1;
      if (clr) begin
        rq.delete();
        rr_next = 0;
        for (int i = 0; i < NUM_CH; i++) hold[i] = '0;
      end else begin
        win = model_pick(req, rr_next);
        if (win >= 0) eg[win] = 1'b1;
        if (rq.size() > 0 && rq[0].due == cyc) begin
          ev[rq[0].ch]   = 1'b1;
          hold[rq[0].ch] = rq[0].data;
          void'(rq.pop_front());
        end
      end
      chk("gnt", 32'(gnt), 32'(eg));
      chk("rvalid", 32'(rvalid), 32'(ev));
      for (int i = 0; i < NUM_CH; i++) chk($sformatf("rdata%0d", i), rdata[i], hold[i]);
      if (win >= 0) begin
        idx = (addr[win] >> 2) % DEPTH;
        if (we[win]) begin
          for (int b = 0; b < 4; b++)
            if (byteEnable[win][b]) mm[idx][8*b +: 8] = wdata[win][8*b +: 8];
          d = '0;
        end else begin
          d = mm[idx];
        end
        rq.push_back('{due: cyc + LAT, ch: win, data: d});
        rr_next = (win + 1) % NUM_CH;
      end
    end
  end

  // Response log used by the directed literal checks
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      for (int i = 0; i < NUM_CH; i++)
        if (rvalid[i]) rlog.push_back('{ch: i, data: rdata[i], t: ncyc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one access on a channel and hold it until granted
  task automatic access(input int ch, input logic w, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] d, output int t_acc);
    bit got;
    got            = 1'b0;
    t_acc          = -1;
    req[ch]        = 1'b1;
    we[ch]         = w;
    byteEnable[ch] = be;
    addr[ch]       = a;
    wdata[ch]      = d;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = gnt[ch];
      tick();
    end
    req[ch] = 1'b0;
    if (got) begin
      t_acc = ncyc;
    end else begin
      checks++;
      errors++;
      $display("FAIL access_timeout ch%0d addr %h: got no grant expected grant", ch, a);
    end
  endtask

  // Take the oldest logged response and compare channel and data
  task automatic wait_resp(input int ch, input logic [31:0] exp, input string name);
    obs_t e;
    int n;
    n = 0;
    while (rlog.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (rlog.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no response expected data %h", name, exp);
    end else begin
      e = rlog.pop_front();
      chk({name, "_ch"}, 32'(e.ch), 32'(ch));
      chk(name, e.data, exp);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    int tacc [4];
    logic [NUM_CH-1:0] g [4];
    int n;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    chk("reset_rdata0", rdata[0], 32'h0);
    chk("reset_rdata1", rdata[1], 32'h0);
    tick();
    clr = 1'b0;
    tick();

    // Store then load on the data channel
    access(1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, t);
    access(1, 1'b0, 4'h0, 32'h10, 32'h0, t);
    wait_resp(1, 32'h0, "store_resp");
    wait_resp(1, 32'hDEADBEEF, "load_0x10");

    // Byte lanes, address wrap and ignored low bits
    access(0, 1'b1, 4'hF, 32'h20, 32'h11223344, t);
    access(0, 1'b1, 4'b0010, 32'h20, 32'h0000AA00, t);
    access(0, 1'b0, 4'h0, 32'h20, 32'h0, t);
    access(0, 1'b0, 4'h0, 32'h20 + DEPTH * 4, 32'h0, t);
    access(0, 1'b0, 4'h0, 32'h23, 32'h0, t);
    wait_resp(0, 32'h0, "be_store_full");
    wait_resp(0, 32'h0, "be_store_lane1");
    wait_resp(0, 32'h1122AA44, "be_load");
    wait_resp(0, 32'h1122AA44, "wrap_load");
    wait_resp(0, 32'h1122AA44, "low_bits_load");

    // Reset with a load in flight
    rlog.delete();
    access(1, 1'b0, 4'h0, 32'h10, 32'h0, t);
    clr    = 1'b1;
    req[0] = 1'b1;
    @(negedge clk);
    chk("gnt_during_clr", 32'(gnt), 32'h0);
    tick();
    tick();
    req[0] = 1'b0;
    clr    = 1'b0;
    repeat (6) tick();
    chk("no_resp_after_clr", 32'(rlog.size()), 32'h0);
    access(1, 1'b0, 4'h0, 32'h10, 32'h0, t);
    wait_resp(1, 32'hDEADBEEF, "mem_kept_after_clr");
    repeat (4) tick();

    // Contention between both channels
    rlog.delete();
    we         = '0;
    byteEnable = '0;
    addr[0]    = 32'h10;
    addr[1]    = 32'h20;
    req        = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      g[k] = gnt;
      tick();
    end
    req[0] = 1'b0;
    @(negedge clk);
    chk("ch1_after_ch0_drops", 32'(gnt), 32'h2);
    tick();
    req[1] = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    chk("rr_gnt0", 32'(g[0]), 32'h1);
    chk("rr_gnt1", 32'(g[1]), 32'h2);
    chk("rr_gnt2", 32'(g[2]), 32'h1);
    chk("rr_gnt3", 32'(g[3]), 32'h2);
    wait_resp(0, 32'hDEADBEEF, "rr_resp0");
    wait_resp(1, 32'h1122AA44, "rr_resp1");
    wait_resp(0, 32'hDEADBEEF, "rr_resp2");
    wait_resp(1, 32'h1122AA44, "rr_resp3");
`else
    chk("fp_gnt0", 32'(g[0]), 32'h1);
    chk("fp_gnt1", 32'(g[1]), 32'h1);
    chk("fp_gnt2", 32'(g[2]), 32'h1);
    chk("fp_gnt3", 32'(g[3]), 32'h1);
    wait_resp(0, 32'hDEADBEEF, "fp_resp0");
    wait_resp(0, 32'hDEADBEEF, "fp_resp1");
    wait_resp(0, 32'hDEADBEEF, "fp_resp2");
    wait_resp(0, 32'hDEADBEEF, "fp_resp3");
`endif
    wait_resp(1, 32'h1122AA44, "late_ch1_resp");
    repeat (4) tick();

    // Back-to-back loads at full throughput
    for (int k = 0; k < 4; k++) access(0, 1'b1, 4'hF, 32'(4 * k), 32'h0BAD0000 + 32'(k), t);
    repeat (6) tick();
    rlog.delete();
    for (int k = 0; k < 4; k++) access(0, 1'b0, 4'h0, 32'(4 * k), 32'h0, tacc[k]);
    n = 0;
    while (rlog.size() < 4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("tput_count", 32'(rlog.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tput_accept%0d", k), 32'(tacc[k]), 32'(tacc[0] + k));
      if (k < rlog.size()) begin
        chk($sformatf("tput_data%0d", k), rlog[k].data, 32'h0BAD0000 + 32'(k));
        chk($sformatf("tput_time%0d", k), 32'(rlog[k].t), 32'(tacc[0] + LAT + k));
      end
    end
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
